// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: in-flight write tracking, MDU busy counter, stall and forward selects.
// Define HAZARD_STATS_EN to add the stall_cnt / md_stall_cnt statistics outputs.
module hazard_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int T_W      = 2,
  parameter int NSTAGE   = 3,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_W-1:0]              d_rs_addr,
  input  logic [ADDR_W-1:0]              d_rt_addr,
  input  logic [T_W-1:0]                 d_rs_tuse,
  input  logic [T_W-1:0]                 d_rt_tuse,
  input  logic                           d_rs_used,
  input  logic                           d_rt_used,
  input  logic [ADDR_W-1:0]              d_wr_addr,
  input  logic [T_W-1:0]                 d_tnew,
  input  logic                           d_md_en,
  input  logic                           d_md_start,
  input  logic                           d_md_is_div,
  output logic                           stall,
  output logic [$clog2(NSTAGE+1)-1:0]    rs_fwd,
  output logic [$clog2(NSTAGE+1)-1:0]    rt_fwd,
  output logic                           md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                    stall_cnt,
  output logic [31:0]                    md_stall_cnt
`endif
);

  localparam int FWD_W  = $clog2(NSTAGE + 1);
  localparam int MD_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CNT_W  = $clog2(MD_MAX + 1);

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  logic [NSTAGE-1:0] sb_vld;
  logic [ADDR_W-1:0] sb_addr [NSTAGE];
  logic [T_W-1:0]    sb_tnew [NSTAGE];

  logic              md_start_e;
  logic              md_is_div_e;
  logic [CNT_W-1:0]  md_cnt;

  logic              rs_hit, rt_hit;
  logic [T_W-1:0]    rs_tn, rt_tn;
  logic [FWD_W-1:0]  rs_sel, rt_sel;
  logic              rs_haz, rt_haz, md_stall;

  // D-stage lookup: scan oldest to youngest so the youngest match wins
  always_comb begin
    rs_hit = 1'b0;
    rs_tn  = '0;
    rs_sel = '0;
    rt_hit = 1'b0;
    rt_tn  = '0;
    rt_sel = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (sb_vld[i] && d_rs_addr != '0 && sb_addr[i] == d_rs_addr) begin
        rs_hit = 1'b1;
        rs_tn  = sb_tnew[i];
        rs_sel = FWD_W'(i + 1);
      end
      if (sb_vld[i] && d_rt_addr != '0 && sb_addr[i] == d_rt_addr) begin
        rt_hit = 1'b1;
        rt_tn  = sb_tnew[i];
        rt_sel = FWD_W'(i + 1);
      end
    end
  end

  assign rs_haz   = d_rs_used & rs_hit & (rs_tn > d_rs_tuse);
  assign rt_haz   = d_rt_used & rt_hit & (rt_tn > d_rt_tuse);
  assign md_busy  = md_start_e | (md_cnt != '0);
  assign md_stall = d_md_en & md_busy;
  assign stall    = rs_haz | rt_haz | md_stall;

  // A match still computing (tnew > 0) is picked up by a later stage's forward path
  assign rs_fwd = (d_rs_used && rs_hit && rs_tn == '0) ? rs_sel : '0;
  assign rt_fwd = (d_rt_used && rt_hit && rt_tn == '0) ? rt_sel : '0;

  // D -> E boundary: control state (entry valids, MDU sequencing)
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_vld     <= '0;
      md_start_e <= 1'b0;
      md_cnt     <= '0;
    end else begin
      sb_vld     <= {sb_vld[NSTAGE-2:0], ~stall & (d_wr_addr != '0)};
      md_start_e <= d_md_start & ~stall;
      if (md_start_e)
        md_cnt <= md_is_div_e ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - 1'b1;
    end
  end

  // D -> E boundary: entry payload, qualified by sb_vld
  always_ff @(posedge clk) begin
    sb_addr[0] <= d_wr_addr;
    sb_tnew[0] <= d_tnew;
    for (int i = 1; i < NSTAGE; i++) begin
      sb_addr[i] <= sb_addr[i-1];
      sb_tnew[i] <= sat_dec(sb_tnew[i-1]);
    end
    if (d_md_start && !stall)
      md_is_div_e <= d_md_is_div;
  end

`ifdef HAZARD_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall)    stall_cnt    <= sat_inc(stall_cnt);
      if (md_stall) md_stall_cnt <= sat_inc(md_stall_cnt);
    end
  end
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised decode-stage hazard unit for the pipelined MIPS core.
- Replaces the fixed Tuse-only decoder with a stateful scoreboard. It tracks in-flight register writes and their remaining Tnew across NSTAGE downstream stages, and runs a busy counter for the multiply/divide unit.
- Generates the D-stage stall and per-operand forwarding-source selects.
- Sits beside the D-stage decoder, which supplies Tuse, Tnew and MDU-use flags.

Parameters:
- ADDR_W, 5: register address width.
- T_W, 2: width of Tuse/Tnew fields.
- NSTAGE, 3: tracked stages after D (index 0 = E, 1 = M, 2 = W).
- MULT_CYC, 5: busy cycles for mult/multu.
- DIV_CYC, 10: busy cycles for div/divu.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- d_rs_addr  in  ADDR_W  rs of the instruction in D
- d_rt_addr  in  ADDR_W  rt of the instruction in D
- d_rs_tuse  in  T_W  cycles until rs is consumed
- d_rt_tuse  in  T_W  cycles until rt is consumed
- d_rs_used  in  1  instruction in D reads rs
- d_rt_used  in  1  instruction in D reads rt
- d_wr_addr  in  ADDR_W  destination register of the D instruction; 0 means no write
- d_tnew  in  T_W  Tnew of the D instruction on entry to E
- d_md_en  in  1  D instruction uses the MDU or HI/LO
- d_md_start  in  1  D instruction starts mult/div
- d_md_is_div  in  1  qualifies d_md_start: 1 = div, 0 = mult
- stall  out  1  freeze PC/F/D and insert a bubble into E
- rs_fwd  out  2  rs forward source: 0 = register file, k = stage k-1
- rt_fwd  out  2  rt forward source, same encoding as rs_fwd
- md_busy  out  1  MDU occupied

Behaviour:
- Scoreboard holds NSTAGE entries {valid, addr, tnew}.
- Every clock edge, entry i for i ≥ 1 takes entry i-1. Its tnew is decremented, saturating at 0. The last entry retires.
- Entry 0 update:
  - stall = 0: entry 0 takes {d_wr_addr != 0, d_wr_addr, d_tnew}.
  - stall = 1: entry 0 becomes a bubble (valid = 0). Downstream entries still shift.
- Matching, per operand X in {rs, rt}:
  - A match is a valid entry with addr == d_X_addr.
  - Addr 0 never matches.
  - The youngest match (lowest index) has priority; older matches are ignored.
- Data-hazard stall: asserted when d_X_used = 1, the operand has a youngest match, and that entry's tnew > d_X_tuse.
- MDU tracking:
  - md_start_e flag is set on an edge where d_md_start = 1 and stall = 0; it clears on the next edge.
  - When md_start_e = 1, md_cnt loads DIV_CYC if the latched type is div, otherwise MULT_CYC.
  - Otherwise md_cnt decrements while nonzero.
  - md_busy = md_start_e | (md_cnt != 0).
- MDU stall: d_md_en & md_busy.
- stall = OR of the rs hazard, the rt hazard and the MDU stall. Purely combinational from inputs and state; no added latency.
- Forward selects:
  - X_fwd = index + 1 of the youngest match when its tnew == 0 and d_X_used = 1.
  - Otherwise X_fwd = 0, including when the youngest match still has tnew > 0; that value is forwarded later downstream.
  - NSTAGE > 3 widens rs_fwd/rt_fwd to clog2(NSTAGE+1).
- Reset:
  - All entries invalid, md_cnt = 0, md_start_e = 0.
  - With the D inputs idle, stall, rs_fwd, rt_fwd and md_busy all read 0.
  - A reset during an MDU operation aborts it immediately.
- Simultaneous events:
  - A new d_md_start while busy is blocked by stall when d_md_en = 1. The decoder guarantees d_md_start implies d_md_en.
  - The counter reaching 0 in the same cycle the D instruction evaluates: md_busy is already 0, so there is no stall.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Adds output stall_cnt[31:0], which counts cycles with stall = 1 and saturates at 0xFFFFFFFF.
  - Adds output md_stall_cnt[31:0], which counts cycles with an MDU stall; same saturation.
  - Both counters clear on reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Load-use: E entry {addr 8, tnew 2} (lw $8), then D add with rs = 8, tuse = 1 → stall = 1 for one cycle. The next cycle has M entry tnew 1, so no stall; the cycle after gives rs_fwd = 3 (W).
- ALU chain: ori $5 (tnew 1), then D sw with rt = 5, tuse = 2 → stall = 0, rt_fwd = 0. The next cycle gives rt_fwd = 2 (M).
- Priority and zero: E {5, tnew 0} and M {5, tnew 0} → rs_fwd = 1. Separately, d_rs_addr = 0 against an entry with addr 0 → no match, rs_fwd = 0.
- Divide: d_md_start with is_div = 1 accepted → md_busy high for 11 cycles (1 + DIV_CYC). A D mfhi during that window → stall = 1 each cycle, releasing on the first cycle md_busy = 0.
- Reset mid-operation: reset asserted 3 cycles into a mult → next cycle md_busy = 0, all entries invalid, stall = 0.
- HAZARD_STATS_EN: run the divide scenario → stall_cnt = 11, md_stall_cnt = 11.
